rr_sel3_arbiter: RTL and testbench

RR_SEL3_ARBITER -- requirements
Module: rr_sel3_arbiter

---
 rtl/rr_sel3_arbiter.sv | 174 +++++++++++++++++
 tb/tb_rr_sel3_arbiter.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/rr_sel3_arbiter.sv
// rr_sel3_arbiter: round-robin arbiter for three sources driving the select of a 3:1 mux.
// Grants are registered. A transfer completes on any edge where valid and ready are both high.
// Optional feature: define RR_SEL3_LOCK_EN to add a lock input. When lock is high during a
// transfer, the arbiter keeps the current grant.
module rr_sel3_arbiter #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [2:0]       req,
`ifdef RR_SEL3_LOCK_EN
    input  logic             lock,
`endif
    input  logic             ready,
    output logic [1:0]       S,
    output logic [2:0]       gnt,
    output logic             valid,
    output logic [CNT_W-1:0] xfer_cnt
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [1:0]       ptr_q,   ptr_d;
    logic [1:0]       s_q,     s_d;
    logic [2:0]       gnt_q,   gnt_d;
    logic             valid_q, valid_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;

    logic [2:0] arb_hold;   // winner searching from the current pointer
    logic [2:0] arb_next;   // winner searching from the granted index (pointer after a transfer)
    logic       granted_live;
    logic       lock_hold;

    // Pick the first set request after pointer p, in the order 0 -> 1 -> 2 -> 0.
    // The source at p itself has the lowest priority.
    function automatic logic [2:0] rr_pick(input logic [1:0] p, input logic [2:0] r);
        logic [2:0] w;
        w = 3'b000;
        case (p)
            2'd0: begin
                if (r[1])      w = 3'b010;
                else if (r[2]) w = 3'b100;
                else if (r[0]) w = 3'b001;
            end
            2'd1: begin
                if (r[2])      w = 3'b100;
                else if (r[0]) w = 3'b001;
                else if (r[1]) w = 3'b010;
            end
            default: begin
                // The pointer is never 3. If it were, it would behave like 2.
                if (r[0])      w = 3'b001;
                else if (r[1]) w = 3'b010;
                else if (r[2]) w = 3'b100;
            end
        endcase
        return w;
    endfunction

    // Convert a one-hot grant to the mux select. A zero grant maps to 0, so 3 can never appear.
    function automatic logic [1:0] onehot_to_sel(input logic [2:0] g);
        logic [1:0] s;
        s = 2'd0;
        if (g[1])      s = 2'd1;
        else if (g[2]) s = 2'd2;
        return s;
    endfunction

    // Search for a winner from both possible pointer positions.
    always_comb begin
        arb_hold     = rr_pick(ptr_q, req);
        arb_next     = rr_pick(s_q, req);
        granted_live = |(req & gnt_q);
    end

`ifdef RR_SEL3_LOCK_EN
    // Lock matters only while the granted source is still requesting.
    always_comb begin
        lock_hold = lock & granted_live;
    end
`else
    // Without the lock feature, the arbiter is pure round-robin.
    always_comb begin
        lock_hold = 1'b0;
    end
`endif

    // Compute the next state, grant, pointer and transfer count.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        s_d     = s_q;
        gnt_d   = gnt_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;

        case (state_q)
            ST_IDLE: begin
                // In IDLE, ready is ignored because valid is low.
                if (|req) begin
                    state_d = ST_GRANT;
                    gnt_d   = arb_hold;
                    s_d     = onehot_to_sel(arb_hold);
                    valid_d = 1'b1;
                end else begin
                    gnt_d   = 3'b000;
                    valid_d = 1'b0;
                end
            end

            ST_GRANT: begin
                if (!granted_live) begin
                    // The requester withdrew. Abandon the grant without a transfer,
                    // leave the pointer alone, and re-arbitrate among the remaining requests.
                    if (|arb_hold) begin
                        gnt_d   = arb_hold;
                        s_d     = onehot_to_sel(arb_hold);
                        valid_d = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                        gnt_d   = 3'b000;
                        valid_d = 1'b0;
                    end
                end else if (ready) begin
                    cnt_d = cnt_q + 1'b1;
                    if (!lock_hold) begin
                        // The granted source is still requesting, so arb_next is never zero here.
                        ptr_d   = s_q;
                        gnt_d   = arb_next;
                        s_d     = onehot_to_sel(arb_next);
                        valid_d = 1'b1;
                    end
                end
                // When ready is low, hold everything. Other requests cannot preempt the grant.
            end

            default: begin
                state_d = ST_IDLE;
                gnt_d   = 3'b000;
                valid_d = 1'b0;
            end
        endcase
    end

    // Register state with asynchronous reset. A pointer of 2 gives source 0 first priority.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ptr_q   <= 2'd2;
            s_q     <= 2'd0;
            gnt_q   <= 3'b000;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            s_q     <= s_d;
            gnt_q   <= gnt_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    // Drive the outputs directly from flops.
    always_comb begin
        S        = s_q;
        gnt      = gnt_q;
        valid    = valid_q;
        xfer_cnt = cnt_q;
    end

endmodule

// File: tb/tb_rr_sel3_arbiter.sv
// Directed testbench for rr_sel3_arbiter. Expected values are computed by hand.
// Inputs change 1 time unit after a rising edge. Outputs are sampled at that same point.
module tb_rr_sel3_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] req = 3'b000;
    logic       ready = 1'b0;
    logic [1:0] S;
    logic [2:0] gnt;
    logic       valid;
    logic [7:0] xfer_cnt;
`ifdef RR_SEL3_LOCK_EN
    logic       lock = 1'b0;
`endif

    // A second instance with CNT_W=2 exercises counter wrap.
    logic [2:0] req2 = 3'b000;
    logic       ready2 = 1'b0;
    logic [1:0] S2;
    logic [2:0] gnt2;
    logic       valid2;
    logic [1:0] xfer_cnt2;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    rr_sel3_arbiter #(.CNT_W(8)) u_dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
`ifdef RR_SEL3_LOCK_EN
        .lock     (lock),
`endif
        .ready    (ready),
        .S        (S),
        .gnt      (gnt),
        .valid    (valid),
        .xfer_cnt (xfer_cnt)
    );

    rr_sel3_arbiter #(.CNT_W(2)) u_dut2 (
        .clk      (clk),
        .rst      (rst),
        .req      (req2),
`ifdef RR_SEL3_LOCK_EN
        .lock     (1'b0),
`endif
        .ready    (ready2),
        .S        (S2),
        .gnt      (gnt2),
        .valid    (valid2),
        .xfer_cnt (xfer_cnt2)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input logic [1:0] s_e, input logic [2:0] g_e,
                             input logic v_e, input logic [7:0] c_e);
        check_eq({tag, ".S"}, {30'd0, S}, {30'd0, s_e});
        check_eq({tag, ".gnt"}, {29'd0, gnt}, {29'd0, g_e});
        check_eq({tag, ".valid"}, {31'd0, valid}, {31'd0, v_e});
        check_eq({tag, ".cnt"}, {24'd0, xfer_cnt}, {24'd0, c_e});
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = 3'b000;
        ready = 1'b0;
        req2 = 3'b000;
        ready2 = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        // Reset state.
        do_reset();
        check_out("reset", 2'b00, 3'b000, 1'b0, 8'd0);

        // In IDLE with no request, ready is ignored.
        ready = 1'b1;
        step();
        check_out("idle_ready", 2'b00, 3'b000, 1'b0, 8'd0);

        // All three sources request with ready held high: grants rotate 0,1,2,0.
        req = 3'b111;
        step(); check_out("rr0", 2'b00, 3'b001, 1'b1, 8'd0);
        step(); check_out("rr1", 2'b01, 3'b010, 1'b1, 8'd1);
        step(); check_out("rr2", 2'b10, 3'b100, 1'b1, 8'd2);
        step(); check_out("rr3", 2'b00, 3'b001, 1'b1, 8'd3);
        step(); check_out("rr4", 2'b01, 3'b010, 1'b1, 8'd4);
        // Requests drop while source 1 is granted: the grant is abandoned and the arbiter goes idle.
        req = 3'b000;
        ready = 1'b0;
        step(); check_out("rr_idle", 2'b01, 3'b000, 1'b0, 8'd4);

        // Source 1 alone, stalled for 5 cycles, then one transfer.
        do_reset();
        req = 3'b010;
        step(); check_out("stall0", 2'b01, 3'b010, 1'b1, 8'd0);
        for (int i = 1; i < 5; i++) begin
            step(); check_out($sformatf("stall%0d", i), 2'b01, 3'b010, 1'b1, 8'd0);
        end
        ready = 1'b1;
        step(); check_out("stall_xfer", 2'b01, 3'b010, 1'b1, 8'd1);
        ready = 1'b0;
        req = 3'b000;
        step(); check_out("stall_idle", 2'b01, 3'b000, 1'b0, 8'd1);

        // Source 2 is granted, then withdraws while source 0 requests: switch to source 0, no count.
        do_reset();
        req = 3'b100;
        step(); check_out("ab_g2", 2'b10, 3'b100, 1'b1, 8'd0);
        req = 3'b001;
        step(); check_out("ab_g0", 2'b00, 3'b001, 1'b1, 8'd0);
        // Source 1 requests while source 0 is stalled: no preemption.
        req = 3'b011;
        step(); check_out("nopreempt", 2'b00, 3'b001, 1'b1, 8'd0);

        // Reset asserted mid-grant takes effect asynchronously.
        do_reset();
        req = 3'b010;
        ready = 1'b1;
        step(); check_out("mr_g", 2'b01, 3'b010, 1'b1, 8'd0);
        step(); check_out("mr_x", 2'b01, 3'b010, 1'b1, 8'd1);
        ready = 1'b0;
        #2 rst = 1'b1;
        #1 check_out("mr_async", 2'b00, 3'b000, 1'b0, 8'd0);
        step();
        rst = 1'b0;
        // After reset release, the first grant still takes one cycle.
        req = 3'b010;
        #2 check_out("mr_pre", 2'b00, 3'b000, 1'b0, 8'd0);
        step(); check_out("mr_post", 2'b01, 3'b010, 1'b1, 8'd0);

        // With CNT_W=2 and continuous transfers from source 0, the counter wraps.
        do_reset();
        req2 = 3'b001;
        ready2 = 1'b1;
        step();
        check_eq("w0.S", {30'd0, S2}, 32'd0);
        check_eq("w0.valid", {31'd0, valid2}, 32'd1);
        check_eq("w0.cnt", {30'd0, xfer_cnt2}, 32'd0);
        for (int i = 1; i <= 4; i++) begin
            step();
            check_eq($sformatf("w%0d.S", i), {30'd0, S2}, 32'd0);
            check_eq($sformatf("w%0d.gnt", i), {29'd0, gnt2}, 32'd1);
            check_eq($sformatf("w%0d.cnt", i), {30'd0, xfer_cnt2}, i % 4);
        end
        req2 = 3'b000;
        ready2 = 1'b0;

`ifdef RR_SEL3_LOCK_EN
        // With lock high, source 0 keeps the grant across transfers. Releasing lock moves on to source 1.
        do_reset();
        req = 3'b011;
        ready = 1'b1;
        lock = 1'b1;
        step(); check_out("lk0", 2'b00, 3'b001, 1'b1, 8'd0);
        step(); check_out("lk1", 2'b00, 3'b001, 1'b1, 8'd1);
        step(); check_out("lk2", 2'b00, 3'b001, 1'b1, 8'd2);
        step(); check_out("lk3", 2'b00, 3'b001, 1'b1, 8'd3);
        lock = 1'b0;
        step(); check_out("lk_rel", 2'b01, 3'b010, 1'b1, 8'd4);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
